// File: rtl/pkt_dma_req_gen.sv
// Packet DMA request generator: turns queue-annotated packet metadata into ring-buffer
// write segments (split on wrap) plus an optional descriptor request. Counters under PKT_DMA_REQ_STATS_EN.
module pkt_dma_req_gen #(
  parameter int RB_AWIDTH      = 16,
  parameter int QUEUE_ID_WIDTH = 13,
  parameter int SIZE_WIDTH     = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      in_meta_valid,
  output logic                      in_meta_ready,
  input  logic [QUEUE_ID_WIDTH-1:0] in_queue_id,
  input  logic [SIZE_WIDTH-1:0]     in_size,
  input  logic                      in_needs_dsc,
  input  logic [RB_AWIDTH-1:0]      in_tail,
  input  logic [RB_AWIDTH-1:0]      in_head,
  input  logic [63:0]               in_buf_addr,
  input  logic [RB_AWIDTH:0]        rb_size,

  output logic                      out_wr_valid,
  input  logic                      out_wr_ready,
  output logic [63:0]               out_wr_addr,
  output logic [SIZE_WIDTH-1:0]     out_wr_flits,
  output logic                      out_wr_first,
  output logic                      out_wr_last,

  output logic                      out_dsc_valid,
  input  logic                      out_dsc_ready,
  output logic [QUEUE_ID_WIDTH-1:0] out_dsc_queue_id,
  output logic [RB_AWIDTH-1:0]      out_dsc_tail,

  output logic [31:0]               drop_cnt,
  output logic [31:0]               pkt_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA0,
    S_DATA1,
    S_DSC
  } state_e;

  localparam logic [RB_AWIDTH:0]   RB_ONE  = {{RB_AWIDTH{1'b0}}, 1'b1};
  localparam logic [RB_AWIDTH-1:0] IDX_ONE = {{(RB_AWIDTH-1){1'b0}}, 1'b1};

  state_e                    state_q;
  logic                      wr_valid_q;
  logic [63:0]               wr_addr_q;
  logic [SIZE_WIDTH-1:0]     wr_flits_q;
  logic                      wr_first_q;
  logic                      wr_last_q;
  logic                      dsc_valid_q;
  logic [QUEUE_ID_WIDTH-1:0] dsc_queue_id_q;
  logic [RB_AWIDTH-1:0]      dsc_tail_q;

  // Per-packet context captured at accept and consumed by later segments.
  logic [SIZE_WIDTH-1:0]     seg1_len_q;
  logic                      needs_dsc_q;
  logic [QUEUE_ID_WIDTH-1:0] queue_id_q;
  logic [RB_AWIDTH-1:0]      new_tail_q;
  logic [63:0]               buf_addr_q;

  logic                      accept;
  logic [RB_AWIDTH-1:0]      mask;
  logic [RB_AWIDTH-1:0]      free;
  logic [RB_AWIDTH:0]        room;
  logic [RB_AWIDTH-1:0]      size_ext;
  logic                      drop;
  logic [SIZE_WIDTH-1:0]     seg0_len;
  logic [SIZE_WIDTH-1:0]     seg1_len;
  logic [RB_AWIDTH-1:0]      new_tail;
  logic [63:0]               tail_addr;

  assign in_meta_ready = (state_q == S_IDLE) & rst_n;
  assign accept        = in_meta_valid & in_meta_ready;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    mask      = '0;
    free      = '0;
    room      = '0;
    size_ext  = '0;
    drop      = 1'b0;
    seg0_len  = '0;
    seg1_len  = '0;
    new_tail  = '0;
    tail_addr = '0;

    mask     = RB_AWIDTH'(rb_size - RB_ONE);
    free     = (in_head - in_tail - IDX_ONE) & mask;
    room     = rb_size - {1'b0, in_tail};
    size_ext = RB_AWIDTH'(in_size);
    drop     = (in_size == '0) || (size_ext > free);
    // room only wins the min when it is smaller than size, so it fits SIZE_WIDTH.
    seg0_len  = (room < {1'b0, size_ext}) ? room[SIZE_WIDTH-1:0] : in_size;
    seg1_len  = in_size - seg0_len;
    new_tail  = (in_tail + size_ext) & mask;
    tail_addr = in_buf_addr + (64'(in_tail) << 6);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      wr_valid_q     <= 1'b0;
      wr_addr_q      <= '0;
      wr_flits_q     <= '0;
      wr_first_q     <= 1'b0;
      wr_last_q      <= 1'b0;
      dsc_valid_q    <= 1'b0;
      dsc_queue_id_q <= '0;
      dsc_tail_q     <= '0;
      seg1_len_q     <= '0;
      needs_dsc_q    <= 1'b0;
      queue_id_q     <= '0;
      new_tail_q     <= '0;
      buf_addr_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && !drop) begin
            state_q     <= S_DATA0;
            wr_valid_q  <= 1'b1;
            wr_addr_q   <= tail_addr;
            wr_flits_q  <= seg0_len;
            wr_first_q  <= 1'b1;
            wr_last_q   <= (seg1_len == '0);
            seg1_len_q  <= seg1_len;
            needs_dsc_q <= in_needs_dsc;
            queue_id_q  <= in_queue_id;
            new_tail_q  <= new_tail;
            buf_addr_q  <= in_buf_addr;
          end
        end

        S_DATA0, S_DATA1: begin
          if (out_wr_ready) begin
            if (state_q == S_DATA0 && seg1_len_q != '0) begin
              state_q    <= S_DATA1;
              wr_addr_q  <= buf_addr_q;
              wr_flits_q <= seg1_len_q;
              wr_first_q <= 1'b0;
              wr_last_q  <= 1'b1;
            end else if (needs_dsc_q) begin
              state_q        <= S_DSC;
              wr_valid_q     <= 1'b0;
              dsc_valid_q    <= 1'b1;
              dsc_queue_id_q <= queue_id_q;
              dsc_tail_q     <= new_tail_q;
            end else begin
              state_q    <= S_IDLE;
              wr_valid_q <= 1'b0;
            end
          end
        end

        S_DSC: begin
          if (out_dsc_ready) begin
            state_q     <= S_IDLE;
            dsc_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          wr_valid_q  <= 1'b0;
          dsc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_wr_valid     = wr_valid_q;
  assign out_wr_addr      = wr_addr_q;
  assign out_wr_flits     = wr_flits_q;
  assign out_wr_first     = wr_first_q;
  assign out_wr_last      = wr_last_q;
  assign out_dsc_valid    = dsc_valid_q;
  assign out_dsc_queue_id = dsc_queue_id_q;
  assign out_dsc_tail     = dsc_tail_q;

`ifdef PKT_DMA_REQ_STATS_EN
  logic [31:0] drop_cnt_q;
  logic [31:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else if (accept) begin
      if (drop) drop_cnt_q <= drop_cnt_q + 32'd1;
      else      pkt_cnt_q  <= pkt_cnt_q + 32'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign pkt_cnt  = pkt_cnt_q;
`else
  assign drop_cnt = '0;
  assign pkt_cnt  = '0;
`endif

endmodule
